// File: rtl/alu_issue_ctrl.sv
// In-order ALU issue controller: FIFO-buffered instructions, one issue per cycle, RAW stall, flush/drain.
// Issue outputs are registered (accept-to-issue >= 2 edges); in_ready drops when the FIFO is full or while draining.
module alu_issue_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         LAT        = 3,
    parameter int         PIPE_DEPTH = 4,
    parameter logic [3:0] NOP_FUNC   = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_rs1,
    input  logic [3:0] in_rs2,
    input  logic [3:0] in_rd,
    input  logic [3:0] in_func,
    input  logic [7:0] in_addr,
    input  logic       flush,
    output logic       iss_valid,
    output logic [3:0] iss_rs1,
    output logic [3:0] iss_rs2,
    output logic [3:0] iss_rd,
    output logic [3:0] iss_func,
    output logic [7:0] iss_addr,
    output logic       busy,
    output logic       drain_done,
    output logic [7:0] stall_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    instr_t                fifo_mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PIPE_DEPTH-1:0] trk_vld_q, trk_vld_d;
    logic [3:0]            trk_rd_q [PIPE_DEPTH];
    logic [3:0]            trk_rd_d [PIPE_DEPTH];
    instr_t                iss_q, iss_d;
    logic                  iss_vld_q, iss_vld_d;
    logic [7:0]            stall_q, stall_d;
    instr_t                head, in_instr;
    logic                  fifo_empty, fifo_full, accept, hazard, issue, idle_all;

    assign in_instr   = {in_rs1, in_rs2, in_rd, in_func, in_addr};
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
    assign in_ready   = !fifo_full && (state_q != DRAIN);
    assign accept     = in_valid && in_ready;
    assign idle_all   = fifo_empty && (trk_vld_q == '0);
    assign busy       = !idle_all;

    // Tracker slot k holds the instruction issued k+1 edges ago; only the youngest LAT-1 can still hide a write.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if ((k < LAT-1) && trk_vld_q[k] &&
                ((trk_rd_q[k] == head.rs1) || (trk_rd_q[k] == head.rs2))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && !fifo_empty;
    end

    assign issue = !fifo_empty && !hazard;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        stall_d   = stall_q;
        iss_d     = iss_q;
        iss_vld_d = issue;
        if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            iss_d    = head;
        end else begin
            iss_d.func = NOP_FUNC;
        end
        if (hazard && (stall_q != 8'hFF)) stall_d = stall_q + 8'd1;
        trk_vld_d   = {trk_vld_q[PIPE_DEPTH-2:0], issue};
        trk_rd_d[0] = head.rd;
        for (int k = 1; k < PIPE_DEPTH; k++) trk_rd_d[k] = trk_rd_q[k-1];
    end

    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            IDLE:  if (flush) state_d = DRAIN;
                   else if (accept) state_d = RUN;
            RUN:   if (flush) state_d = DRAIN;
                   else if (idle_all && !accept) state_d = IDLE;
            DRAIN: if (idle_all) begin
                       drain_done = 1'b1;
                       state_d    = IDLE;
                   end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            trk_vld_q <= '0;
            iss_vld_q <= 1'b0;
            iss_q     <= '{rs1: 4'd0, rs2: 4'd0, rd: 4'd0, func: NOP_FUNC, addr: 8'd0};
            stall_q   <= 8'd0;
            for (int k = 0; k < PIPE_DEPTH; k++) trk_rd_q[k] <= 4'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            trk_vld_q <= trk_vld_d;
            iss_vld_q <= iss_vld_d;
            iss_q     <= iss_d;
            stall_q   <= stall_d;
            for (int k = 0; k < PIPE_DEPTH; k++) trk_rd_q[k] <= trk_rd_d[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) fifo_mem[wr_ptr_q[AW-1:0]] <= in_instr;
    end

    assign iss_valid = iss_vld_q;
    assign iss_rs1   = iss_q.rs1;
    assign iss_rs2   = iss_q.rs2;
    assign iss_rd    = iss_q.rd;
    assign iss_func  = iss_q.func;
    assign iss_addr  = iss_q.addr;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table, directed corner sequences and a random run against a timestamp model.
module tb_alu_issue_ctrl;
    localparam int FIFO_DEPTH = 4;
    localparam int LAT        = 3;
    localparam int PIPE_DEPTH = 4;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } ins_t;

    typedef struct {
        logic       v;
        ins_t       ins;
        logic       e_vld;
        logic [3:0] e_func;
        logic [3:0] e_rd;
        logic       e_busy;
        logic [7:0] e_st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, flush = 1'b0;
    logic [3:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
    logic [7:0] in_addr = '0;
    logic in_ready, iss_valid, busy, drain_done;
    logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0] iss_addr, stall_cnt;

    alu_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .LAT(LAT), .PIPE_DEPTH(PIPE_DEPTH), .NOP_FUNC(4'd15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .flush(flush), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_func(iss_func), .iss_addr(iss_addr),
        .busy(busy), .drain_done(drain_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending queue plus the edge number at which each register was last written by an issue.
    ins_t       mq[$];
    int         last_wr[16];
    int         last_iss;
    bit         draining;
    int         n = 0;
    ins_t       e_iss;
    logic       e_vld;
    logic [7:0] e_stall;
    logic [7:0] seen[$];
    bit         last_acc;
    bit         saw_block;

    localparam logic [35:0] RST_V = {1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 8'h00, 1'b0, 1'b0, 8'h00};

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [35:0] pack_act();
        return {in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr, busy, drain_done, stall_cnt};
    endfunction

    function automatic logic [35:0] model_exp();
        bit inflight, m_busy, rdy;
        inflight = (n - last_iss) < PIPE_DEPTH;
        m_busy   = (mq.size() > 0) || inflight;
        rdy      = (mq.size() < FIFO_DEPTH) && !draining;
        return {rdy, e_vld, e_iss, m_busy, draining && !m_busy, e_stall};
    endfunction

    task automatic model_edge(input logic v, input ins_t ins, input logic fl, input logic r);
        bit   rdy, acc, haz, iss, quiet;
        ins_t h;
        n++;
        if (r) begin
            mq.delete();
            foreach (last_wr[i]) last_wr[i] = -100;
            last_iss = -100;
            draining = 0;
            e_vld    = 1'b0;
            e_iss    = '0;
            e_iss.func = 4'd15;
            e_stall  = 8'd0;
            return;
        end
        rdy = (mq.size() < FIFO_DEPTH) && !draining;
        acc = v && rdy;
        haz = 0;
        iss = 0;
        h   = '0;
        if (mq.size() > 0) begin
            h   = mq[0];
            haz = ((n - last_wr[h.rs1]) < LAT) || ((n - last_wr[h.rs2]) < LAT);
            iss = !haz;
        end
        quiet = (mq.size() == 0) && !(((n - 1) - last_iss) < PIPE_DEPTH);
        if (draining && quiet) draining = 0;
        else if (!draining && fl) draining = 1;
        if (iss) begin
            e_vld = 1'b1;
            e_iss = h;
            last_wr[h.rd] = n;
            last_iss = n;
            void'(mq.pop_front());
        end else begin
            e_vld = 1'b0;
            e_iss.func = 4'd15;
        end
        if (haz && e_stall != 8'hFF) e_stall = e_stall + 8'd1;
        if (acc) mq.push_back(ins);
    endtask

    task automatic cyc(input logic v, input ins_t ins, input logic fl, input logic r);
        logic [35:0] exp;
        in_valid = v;
        in_rs1 = ins.rs1; in_rs2 = ins.rs2; in_rd = ins.rd; in_func = ins.func; in_addr = ins.addr;
        flush = fl;
        rst   = r;
        last_acc = v && (in_ready === 1'b1) && !r;
        model_edge(v, ins, fl, r);
        exp = model_exp();
        @(posedge clk);
        #1;
        check($sformatf("model_n%0d", n), pack_act(), exp);
        if (iss_valid === 1'b1) seen.push_back(iss_addr);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic push(input ins_t ins);
        int tries;
        bit done;
        tries = 0;
        done  = 0;
        while (!done) begin
            if (in_ready !== 1'b1) saw_block = 1;
            cyc(1'b1, ins, 1'b0, 1'b0);
            done = last_acc;
            tries++;
            if (!done && tries > 60) begin
                total++;
                bad++;
                $display("FAIL push_timeout: addr %h never accepted", ins.addr);
                done = 1;
            end
        end
    endtask

    function automatic vec_t mk(input logic v, input ins_t ins, input logic e_vld_i, input logic [3:0] e_func,
                                input logic [3:0] e_rd, input logic e_busy, input logic [7:0] e_st);
        vec_t r;
        r.v = v; r.ins = ins; r.e_vld = e_vld_i; r.e_func = e_func;
        r.e_rd = e_rd; r.e_busy = e_busy; r.e_st = e_st;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[19];
        ins_t add_i, mul_i, sub_i, sla_i, a2, s2, o2, x;
        int last_vld, dd_idx, pulses;
        logic busy_at_dd;
        int fl_hold;
        ins_t ri;

        add_i = {4'd3, 4'd5, 4'd10, 4'd0, 8'd125};
        mul_i = {4'd3, 4'd8, 4'd12, 4'd2, 8'd126};
        sub_i = {4'd1, 4'd5, 4'd14, 4'd1, 8'd128};
        sla_i = {4'd7, 4'd3, 4'd13, 4'd3, 8'd127};
        a2    = {4'd3, 4'd5, 4'd10, 4'd0, 8'd1};
        s2    = {4'd10, 4'd5, 4'd14, 4'd1, 8'd2};
        o2    = {4'd1, 4'd2, 4'd6, 4'd4, 8'd3};

        tbl[0]  = mk(1, add_i, 0, 4'd15, 4'd0,  1, 0);
        tbl[1]  = mk(1, mul_i, 1, 4'd0,  4'd10, 1, 0);
        tbl[2]  = mk(1, sub_i, 1, 4'd2,  4'd12, 1, 0);
        tbl[3]  = mk(1, sla_i, 1, 4'd1,  4'd14, 1, 0);
        tbl[4]  = mk(0, '0,    1, 4'd3,  4'd13, 1, 0);
        tbl[5]  = mk(0, '0,    0, 4'd15, 4'd13, 1, 0);
        tbl[6]  = mk(0, '0,    0, 4'd15, 4'd13, 1, 0);
        tbl[7]  = mk(0, '0,    0, 4'd15, 4'd13, 1, 0);
        tbl[8]  = mk(0, '0,    0, 4'd15, 4'd13, 0, 0);
        tbl[9]  = mk(1, a2,    0, 4'd15, 4'd13, 1, 0);
        tbl[10] = mk(1, s2,    1, 4'd0,  4'd10, 1, 0);
        tbl[11] = mk(1, o2,    0, 4'd15, 4'd10, 1, 1);
        tbl[12] = mk(0, '0,    0, 4'd15, 4'd10, 1, 2);
        tbl[13] = mk(0, '0,    1, 4'd1,  4'd14, 1, 2);
        tbl[14] = mk(0, '0,    1, 4'd4,  4'd6,  1, 2);
        tbl[15] = mk(0, '0,    0, 4'd15, 4'd6,  1, 2);
        tbl[16] = mk(0, '0,    0, 4'd15, 4'd6,  1, 2);
        tbl[17] = mk(0, '0,    0, 4'd15, 4'd6,  1, 2);
        tbl[18] = mk(0, '0,    0, 4'd15, 4'd6,  0, 2);

        // Reset state
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("reset_state", pack_act(), RST_V);
        idle(1);
        check("reset_idle", pack_act(), RST_V);

        // Independent stream then RAW pair
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].v, tbl[i].ins, 1'b0, 1'b0);
            check($sformatf("tbl_row%0d", i),
                  {iss_valid, iss_func, iss_rd, busy, stall_cnt},
                  {tbl[i].e_vld, tbl[i].e_func, tbl[i].e_rd, tbl[i].e_busy, tbl[i].e_st});
        end

        // Back-pressure: dependent chain fills the FIFO; order must be preserved
        cyc(1'b0, '0, 1'b0, 1'b1);
        seen.delete();
        saw_block = 0;
        for (int i = 0; i < 8; i++) push({4'd9, 4'd9, 4'd9, 4'd5, 8'(8'h40 + i)});
        idle(40);
        check("bp_blocked", 36'(saw_block), 36'd1);
        check("bp_count", 36'(seen.size()), 36'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("bp_order%0d", i), (i < seen.size()) ? 36'(seen[i]) : 36'hFFF, 36'(8'h40 + i));

        // Drain with two instructions
        seen.delete();
        push({4'd1, 4'd2, 4'd3, 4'd0, 8'h51});
        push({4'd4, 4'd5, 4'd6, 4'd1, 8'h52});
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("drain_rdy_low", 36'(in_ready), 36'd0);
        last_vld = (iss_valid === 1'b1) ? 0 : -1;
        dd_idx = -1; pulses = 0; busy_at_dd = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            if (iss_valid === 1'b1) last_vld = i;
            if (drain_done === 1'b1) begin
                pulses++;
                dd_idx = i;
                busy_at_dd = busy;
            end
        end
        check("drain_pulses", 36'(pulses), 36'd1);
        check("drain_delay", 36'(dd_idx - last_vld), 36'(PIPE_DEPTH));
        check("drain_busy", 36'(busy_at_dd), 36'd0);
        check("drain_issued", {4'(seen.size()), (seen.size() == 2) ? {seen[0], seen[1]} : 16'h0}, {4'd2, 8'h51, 8'h52});

        // Flush while idle, then flush held high
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("flush_idle_dd", 36'(drain_done), 36'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("flush_idle_dd_end", 36'(drain_done), 36'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, '0, (i < 4) ? 1'b1 : 1'b0, 1'b0);
            if (drain_done === 1'b1) pulses++;
        end
        check("flush_held_pulses", 36'(pulses), 36'd2);

        // Mid-operation reset
        for (int i = 0; i < 5; i++) push({4'd9, 4'd9, 4'd9, 4'd2, 8'(8'h60 + i)});
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("midrst_state", pack_act(), RST_V);
        x = {4'd9, 4'd9, 4'd2, 4'd0, 8'h70};
        cyc(1'b1, x, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("midrst_reissue", {iss_valid, iss_addr, stall_cnt}, {1'b1, 8'h70, 8'h00});
        idle(6);

        // Stall counter saturation
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 140; i++) push({4'd9, 4'd9, 4'd9, 4'd6, 8'(i)});
        idle(10);
        check("stall_saturate", 36'(stall_cnt), 36'd255);

        // Random run against the model
        cyc(1'b0, '0, 1'b0, 1'b1);
        fl_hold = 0;
        for (int i = 0; i < 1500; i++) begin
            ri.rs1  = 4'($urandom_range(0, 3));
            ri.rs2  = 4'($urandom_range(0, 3));
            ri.rd   = 4'($urandom_range(0, 3));
            ri.func = 4'($urandom_range(0, 14));
            ri.addr = 8'($urandom_range(0, 255));
            if (fl_hold == 0 && $urandom_range(0, 49) == 0) fl_hold = $urandom_range(1, 3);
            cyc($urandom_range(0, 9) < 6, ri, fl_hold > 0, $urandom_range(0, 199) == 0);
            if (fl_hold > 0) fl_hold--;
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
